// File: rtl/tcdm_responder_pkg.sv
// Shared constants and helpers for the single-bank TCDM responder.
package tcdm_responder_package;

    localparam logic [15:0] STALL_LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of taps 16,14,13,11 (state bits 0,2,3,5)
    localparam logic [15:0] STALL_LFSR_TAPS = 16'h002D;
    localparam logic [1:0]  STALL_MASK      = 2'b11;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & STALL_LFSR_TAPS), s[15:1]};
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_tcdm.sv
// TCDM request/response bundle between a streamer (master) and memory (slave).
interface hwpe_stream_intf_tcdm #(
    parameter int unsigned DW = 32
) ();

    logic          req;
    logic          gnt;
    logic [31:0]   add;
    logic          wen;
    logic [DW/8-1:0] be;
    logic [DW-1:0] data;
    logic [DW-1:0] r_data;
    logic          r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);

endinterface

// File: rtl/tcdm_responder_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module tcdm_rr_arbiter import tcdm_responder_package::*; #(
    parameter int unsigned NB_PORTS = 3,
    localparam int unsigned IW = idx_width(NB_PORTS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                en_i,
    input  logic [NB_PORTS-1:0] req_i,
    output logic [NB_PORTS-1:0] gnt_o,
    output logic [IW-1:0]       idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    int unsigned   cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        if (en_i) begin
            for (int unsigned off = 0; off < NB_PORTS; off++) begin
                cand = 32'(ptr_q) + off;
                if (cand >= NB_PORTS) cand = cand - NB_PORTS;
                if (!found && req_i[IW'(cand)]) begin
                    found              = 1'b1;
                    gnt_o[IW'(cand)]   = 1'b1;
                    idx_o              = IW'(cand);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (|gnt_o) begin
            ptr_d = (idx_o == IW'(NB_PORTS - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/tcdm_responder.sv
// Single-bank TCDM responder: RR arbitration, one access/cycle, response one cycle after grant.
// Optional random back-pressure enabled by defining TCDM_RESPONDER_STALL_EN.
module tcdm_responder import tcdm_responder_package::*; #(
    parameter int unsigned NB_PORTS   = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input logic                 clk_i,
    input logic                 rst_i,
    input logic                 clear_i,
    hwpe_stream_intf_tcdm.slave tcdm [NB_PORTS-1:0]
);

    localparam int unsigned BW = DATA_WIDTH / 8;
    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned IW = idx_width(NB_PORTS);

    logic [NB_PORTS-1:0]   req, gnt, rvalid_q;
    logic [31:0]           add_s  [NB_PORTS];
    logic                  wen_s  [NB_PORTS];
    logic [BW-1:0]         be_s   [NB_PORTS];
    logic [DATA_WIDTH-1:0] data_s [NB_PORTS];

    logic [IW-1:0]         gidx;
    logic                  stall, arb_en;
    logic [31:0]           add_sel;
    logic [AW-1:0]         widx;
    logic                  wen_sel;
    logic [BW-1:0]         be_sel;
    logic [DATA_WIDTH-1:0] data_sel;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic                  unused_add;

    for (genvar i = 0; i < NB_PORTS; i++) begin : g_port
        assign req[i]    = tcdm[i].req;
        assign add_s[i]  = tcdm[i].add;
        assign wen_s[i]  = tcdm[i].wen;
        assign be_s[i]   = tcdm[i].be;
        assign data_s[i] = tcdm[i].data;
        assign tcdm[i].gnt = gnt[i];
        // A response due during clear is dropped, not just cleared at the next edge
        assign tcdm[i].r_valid = rvalid_q[i] & ~clear_i;
        assign tcdm[i].r_data  = (rvalid_q[i] && !clear_i) ? rdata_q : '0;

        tcdm_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
            (req[i] && !gnt[i]) |=> (req[i] && $stable(add_s[i]) && $stable(wen_s[i])
                                     && $stable(be_s[i]) && $stable(data_s[i])));
    end

`ifdef TCDM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = clear_i ? STALL_LFSR_SEED : lfsr_next(lfsr_q);
    assign stall  = (lfsr_q[1:0] & STALL_MASK) == 2'b00;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= STALL_LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign stall = 1'b0;
`endif

    assign arb_en = ~rst_i & ~clear_i & ~stall;

    tcdm_rr_arbiter #(.NB_PORTS(NB_PORTS)) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .en_i    (arb_en),
        .req_i   (req),
        .gnt_o   (gnt),
        .idx_o   (gidx)
    );

    assign add_sel    = add_s[gidx];
    assign wen_sel    = wen_s[gidx];
    assign be_sel     = be_s[gidx];
    assign data_sel   = data_s[gidx];
    assign widx       = add_sel[AW+1:2];
    assign unused_add = ^{add_sel[31:AW+2], add_sel[1:0]};

    always_comb begin
        rdata_d = '0;
        if (|gnt && wen_sel) rdata_d = mem_q[widx];
    end

    always_ff @(posedge clk_i) begin
        if (|gnt && !wen_sel) begin
            for (int unsigned b = 0; b < BW; b++) begin
                if (be_sel[b]) mem_q[widx][8*b +: 8] <= data_sel[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_tcdm_responder.sv
// Bench for tcdm_responder: directed vector table plus a cycle model with response scoreboard.
module tb_tcdm_responder;

    localparam int unsigned NB   = 3;
    localparam int unsigned MEMD = 1024;
    localparam int unsigned AWB  = $clog2(MEMD);

    typedef struct {
        int unsigned port;
        logic        wen;
        logic [31:0] add;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int unsigned port;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic rst_i, clear_i;
    logic [NB-1:0] req_r;
    logic [31:0]   add_r  [NB];
    logic          wen_r  [NB];
    logic [3:0]    be_r   [NB];
    logic [31:0]   data_r [NB];
    logic [NB-1:0] gnt_w, rv_w;
    logic [31:0]   rd_w   [NB];

    int unsigned n_vec = 0;
    int unsigned n_miss = 0;

    logic [31:0] mem_m [MEMD];
    int unsigned ptr_m;
    logic [15:0] lfsr_m;
    resp_t       sb[$];
    vec_t        tbl[9];

    always #5 clk = ~clk;

    hwpe_stream_intf_tcdm #(.DW(32)) tcdm [NB-1:0] ();

    for (genvar g = 0; g < NB; g++) begin : g_if
        assign tcdm[g].req  = req_r[g];
        assign tcdm[g].add  = add_r[g];
        assign tcdm[g].wen  = wen_r[g];
        assign tcdm[g].be   = be_r[g];
        assign tcdm[g].data = data_r[g];
        assign gnt_w[g] = tcdm[g].gnt;
        assign rv_w[g]  = tcdm[g].r_valid;
        assign rd_w[g]  = tcdm[g].r_data;
    end

    tcdm_responder #(.NB_PORTS(NB), .DATA_WIDTH(32), .MEM_DEPTH(MEMD)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .tcdm    (tcdm)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle: compare responses and grants against the model, then advance the model.
    task automatic probe();
        logic [NB-1:0] eg;
        resp_t         r;
        logic          have_r, found, stall;
        int unsigned   c, sel;
        logic [AWB-1:0] w;
        @(negedge clk);
        have_r = 1'b0;
        r = '{0, 32'h0};
        if (rst_i || clear_i || sb.size() == 0) begin
            sb.delete();
            chk("rvalid_idle", 32'(rv_w), 32'h0);
        end else begin
            r = sb.pop_front();
            have_r = 1'b1;
            chk("rvalid", 32'(rv_w), 32'(1) << r.port);
        end
        for (int unsigned p = 0; p < NB; p++)
            chk($sformatf("rdata_p%0d", p), rd_w[p], (have_r && p == r.port) ? r.data : 32'h0);

`ifdef TCDM_RESPONDER_STALL_EN
        stall = (lfsr_m[1:0] == 2'b00);
`else
        stall = 1'b0;
`endif
        eg = '0;
        found = 1'b0;
        sel = 0;
        if (!rst_i && !clear_i && !stall) begin
            for (int unsigned off = 0; off < NB; off++) begin
                c = (ptr_m + off) % NB;
                if (!found && req_r[c]) begin
                    found = 1'b1;
                    sel = c;
                    eg[c] = 1'b1;
                end
            end
        end
        chk("gnt", 32'(gnt_w), 32'(eg));
        if (found) begin
            w = add_r[sel][AWB+1:2];
            sb.push_back('{sel, wen_r[sel] ? mem_m[w] : 32'h0});
            if (!wen_r[sel]) begin
                for (int unsigned b = 0; b < 4; b++)
                    if (be_r[sel][b]) mem_m[w][8*b +: 8] = data_r[sel][8*b +: 8];
            end
            ptr_m = (sel + 1) % NB;
        end
        if (rst_i || clear_i) begin
            ptr_m  = 0;
            lfsr_m = 16'hACE1;
        end else begin
            lfsr_m = lfsr_step(lfsr_m);
        end
    endtask

    task automatic wait_gnt(input int unsigned p, input string name);
        int unsigned k = 0;
        while (!gnt_w[p] && k < 20) begin
            step();
            probe();
            k++;
        end
        chk(name, 32'(gnt_w[p]), 32'h1);
    endtask

    // Release each still-requesting port only after it has been granted.
    task automatic drain();
        logic [NB-1:0] last;
        int unsigned   k = 0;
        last = gnt_w;
        while (req_r != '0 && k < 50) begin
            step();
            req_r = req_r & ~last;
            probe();
            last = gnt_w;
            k++;
        end
        chk("drain", 32'(req_r), 32'h0);
    endtask

    task automatic set_read(input int unsigned p, input logic [31:0] a);
        req_r[p]  = 1'b1;
        wen_r[p]  = 1'b1;
        add_r[p]  = a;
        be_r[p]   = 4'hF;
        data_r[p] = 32'h0;
    endtask

    initial begin
        vec_t v, prev;
        logic have_prev;
        int unsigned got, k, done, cyc;
        logic [NB-1:0] busy;
        logic [31:0] a;

        tbl[0] = '{0, 1'b1, 32'h0000_0014, 4'hF, 32'h0,         32'hDEADBEEF};
        tbl[1] = '{2, 1'b0, 32'h0000_0020, 4'h5, 32'h11223344,  32'h0};
        tbl[2] = '{0, 1'b1, 32'h0000_0020, 4'hF, 32'h0,         32'hAA22CC44};
        tbl[3] = '{1, 1'b1, 32'h0000_1014, 4'hF, 32'h0,         32'hDEADBEEF};
        tbl[4] = '{1, 1'b0, 32'h0000_0017, 4'h8, 32'h55000000,  32'h0};
        tbl[5] = '{2, 1'b1, 32'h0000_1016, 4'hF, 32'h0,         32'h55ADBEEF};
        tbl[6] = '{0, 1'b0, 32'h0000_0FFC, 4'hF, 32'h0BADF00D,  32'h0};
        tbl[7] = '{2, 1'b1, 32'hFFFF_FFFC, 4'hF, 32'h0,         32'h0BADF00D};
        tbl[8] = '{1, 1'b1, 32'h0000_0020, 4'h0, 32'h0,         32'hAA22CC44};

        rst_i = 1'b1;
        clear_i = 1'b0;
        req_r = '0;
        for (int unsigned p = 0; p < NB; p++) begin
            add_r[p] = '0; wen_r[p] = 1'b1; be_r[p] = '0; data_r[p] = '0;
        end
        ptr_m = 0;
        lfsr_m = 16'hACE1;
        for (int unsigned w = 0; w < MEMD; w++) begin
            mem_m[w] = $urandom;
            dut.mem_q[w] = mem_m[w];
        end
        mem_m[5] = 32'hDEADBEEF; dut.mem_q[5] = 32'hDEADBEEF;
        mem_m[8] = 32'hAABBCCDD; dut.mem_q[8] = 32'hAABBCCDD;

        repeat (3) begin step(); probe(); end
        step();
        rst_i = 1'b0;
        probe();
        chk("reset_ptr", 32'(dut.u_arb.ptr_q), 32'h0);

        // Directed single-port accesses, pipelined back to back
        have_prev = 1'b0;
        prev = tbl[0];
        for (int unsigned i = 0; i < 9; i++) begin
            v = tbl[i];
            step();
            req_r = '0;
            req_r[v.port] = 1'b1; wen_r[v.port] = v.wen; add_r[v.port] = v.add;
            be_r[v.port] = v.be; data_r[v.port] = v.data;
            probe();
            if (have_prev) begin
                chk($sformatf("vec%0d_rvalid", i - 1), 32'(rv_w[prev.port]), 32'h1);
                chk($sformatf("vec%0d_rdata", i - 1), rd_w[prev.port], prev.exp);
            end
            wait_gnt(v.port, $sformatf("vec%0d_gnt", i));
            prev = v;
            have_prev = 1'b1;
        end
        step();
        req_r = '0;
        probe();
        chk("vec8_rvalid", 32'(rv_w[prev.port]), 32'h1);
        chk("vec8_rdata", rd_w[prev.port], prev.exp);

        // Clear in the cycle after a grant, then round-robin from port 0
        step();
        set_read(1, 32'h14);
        probe();
        wait_gnt(1, "clr_pre_gnt");
        step();
        clear_i = 1'b1;
        set_read(0, 32'h20);
        set_read(2, 32'h1014);
        probe();
        chk("clear_rvalid", 32'(rv_w), 32'h0);
        chk("clear_gnt", 32'(gnt_w), 32'h0);
        step();
        clear_i = 1'b0;
        probe();
        got = 0;
        k = 0;
        while (got < 6 && k < 40) begin
            if (gnt_w != '0) begin
                chk($sformatf("rr%0d", got), 32'(gnt_w), 32'(1) << (got % NB));
                got++;
            end
            if (got < 6) begin step(); probe(); end
            k++;
        end
        chk("rr_count", got, 32'd6);
        drain();

        // Async reset in the grant cycle: response lost, pointer back to 0
        step();
        set_read(1, 32'h20);
        probe();
        wait_gnt(1, "rst_pre1_gnt");
        step();
        req_r = '0;
        set_read(0, 32'h14);
        probe();
        wait_gnt(0, "rst_pre0_gnt");
        #1 rst_i = 1'b1;
        #1;
        chk("rst_gnt", 32'(gnt_w), 32'h0);
        chk("rst_rvalid_async", 32'(rv_w), 32'h0);
        for (int unsigned p = 0; p < NB; p++)
            chk($sformatf("rst_rdata_async_p%0d", p), rd_w[p], 32'h0);
        step();
        chk("rst_ptr", 32'(dut.u_arb.ptr_q), 32'h0);
        chk("rst_no_resp", 32'(rv_w), 32'h0);
        probe();
        step();
        rst_i = 1'b0;
        set_read(1, 32'h20);
        set_read(2, 32'h1014);
        probe();
        k = 0;
        while (gnt_w == '0 && k < 20) begin step(); probe(); k++; end
        chk("rst_first_gnt", 32'(gnt_w), 32'h1);
        drain();

        // Random traffic, requests held until granted
        busy = '0;
        done = 0;
        cyc = 0;
        while ((done < 1000 || busy != '0) && cyc < 20000) begin
            step();
            for (int unsigned p = 0; p < NB; p++) begin
                if (!busy[p]) begin
                    if (done < 1000 && $urandom_range(0, 1) == 1) begin
                        a = $urandom;
                        a[AWB+1:6] = '0;
                        req_r[p]  = 1'b1;
                        add_r[p]  = a;
                        wen_r[p]  = 1'($urandom_range(0, 1));
                        be_r[p]   = 4'($urandom_range(0, 15));
                        data_r[p] = $urandom;
                        busy[p]   = 1'b1;
                    end else begin
                        req_r[p] = 1'b0;
                    end
                end
            end
            probe();
            for (int unsigned p = 0; p < NB; p++)
                if (gnt_w[p]) begin busy[p] = 1'b0; done++; end
            cyc++;
        end
        chk("rand_done", 32'(done >= 1000), 32'h1);
        step();
        req_r = '0;
        probe();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, %0d miscompares so far", n_miss);
        $fatal(1);
    end

endmodule
